// File: rtl/arb_pkg.sv
// Shared types and helpers for the four-way round-robin bus arbiter.
//   arb_state_t : arbiter FSM state encoding
//   NUM_REQ     : number of requesters sharing the bus
//   rr_pick     : returns the first asserted request at or after ptr (mod 4)
package arb_pkg;

  localparam int NUM_REQ = 4;

  typedef enum logic {ARB_IDLE, ARB_BUSY} arb_state_t;

  // Search ptr, ptr+1, ptr+2, ptr+3; the 2-bit index wraps naturally.
  // Returns ptr when nothing is requesting (caller only uses it when req != 0).
  function automatic logic [1:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                         input logic [1:0]         ptr);
    logic [1:0] idx;
    logic       found;
    rr_pick = ptr;
    found   = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = ptr + 2'(i);
      if (!found && req[idx]) begin
        rr_pick = idx;
        found   = 1'b1;
      end
    end
  endfunction

endpackage

// File: rtl/Mux4.sv
// Four-input WIDTH-bit datapath multiplexer steered by the arbiter's select.
//   in0..in3 : candidate data buses
//   sel      : index of the bus driven onto out
//   out      : selected data
module Mux4 #(
  parameter int WIDTH = 64
) (
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [WIDTH-1:0] in3,
  input  logic [1:0]       sel,
  output logic [WIDTH-1:0] out
);

  always_comb begin
    out = in0;
    case (sel)
      2'd1:    out = in1;
      2'd2:    out = in2;
      2'd3:    out = in3;
      default: out = in0;
    endcase
  end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter sharing one WIDTH-bit downstream port between four
// requesters. A grant is held until the owner drops its request or until
// MAX_BEATS beats have been accepted, followed by one idle cycle.
//   clk, rst_n        : clock, async active-low reset
//   req[3:0]          : per-requester request
//   data0..data3      : per-requester data (not registered here)
//   bus_ready         : downstream accepts the current beat
//   gnt[3:0]          : one-hot grant, zero when idle
//   sel[1:0]          : granted index / mux select
//   bus_valid         : beat valid toward downstream
//   bus_data          : muxed data of the granted requester
//   busy              : high while a grant is active
//
// state    | meaning
// ARB_IDLE | no grant; arbitrate among req using ptr as top priority
// ARB_BUSY | grant held for requester sel; beats counted in beat_cnt
module mux4_rr_arbiter
  import arb_pkg::*;
#(
  parameter int WIDTH     = 64,
  parameter int MAX_BEATS = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       req,
  input  logic [WIDTH-1:0] data0,
  input  logic [WIDTH-1:0] data1,
  input  logic [WIDTH-1:0] data2,
  input  logic [WIDTH-1:0] data3,
  input  logic             bus_ready,
  output logic [3:0]       gnt,
  output logic [1:0]       sel,
  output logic             bus_valid,
  output logic [WIDTH-1:0] bus_data,
  output logic             busy
);

  localparam int            BW       = $clog2(MAX_BEATS + 1);
  localparam logic [BW-1:0] LAST_CNT = BW'(MAX_BEATS - 1);

  arb_state_t    state, state_nxt;
  logic [3:0]    gnt_nxt;
  logic [1:0]    sel_nxt;
  logic [1:0]    ptr, ptr_nxt;
  logic [BW-1:0] beat_cnt, cnt_nxt;
  logic [1:0]    winner;
  logic          beat;

  assign busy      = (state == ARB_BUSY);
  assign bus_valid = busy && req[sel];
  assign beat      = bus_valid && bus_ready;
  assign winner    = rr_pick(req, ptr);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ARB_IDLE;
      gnt      <= 4'b0000;
      sel      <= 2'd0;
      ptr      <= 2'd0;
      beat_cnt <= '0;
    end else begin
      state    <= state_nxt;
      gnt      <= gnt_nxt;
      sel      <= sel_nxt;
      ptr      <= ptr_nxt;
      beat_cnt <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    gnt_nxt   = gnt;
    sel_nxt   = sel;
    ptr_nxt   = ptr;
    cnt_nxt   = beat_cnt;
    case (state)
      ARB_IDLE: begin
        if (req != 4'b0000) begin
          state_nxt = ARB_BUSY;
          gnt_nxt   = 4'b0001 << winner;
          sel_nxt   = winner;
          cnt_nxt   = '0;
        end
      end
      ARB_BUSY: begin
        // A dropped request releases without a beat because bus_valid is
        // already low, so both release causes share one branch.
        if (!req[sel] || (beat && beat_cnt == LAST_CNT)) begin
          state_nxt = ARB_IDLE;
          gnt_nxt   = 4'b0000;
          ptr_nxt   = sel + 2'd1;
        end else if (beat) begin
          cnt_nxt = beat_cnt + BW'(1);
        end
      end
      default: begin
        state_nxt = ARB_IDLE;
        gnt_nxt   = 4'b0000;
      end
    endcase
  end

  Mux4 #(.WIDTH(WIDTH)) u_mux (
    .in0 (data0),
    .in1 (data1),
    .in2 (data2),
    .in3 (data3),
    .sel (sel),
    .out (bus_data)
  );

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
module tb_mux4_rr_arbiter;

  localparam int WIDTH = 64;
  localparam logic [WIDTH-1:0] DPAT [4] = '{64'h0123_4567_89AB_CDEF,
                                            64'hFEDC_BA98_7654_3210,
                                            64'hA5A5_5A5A_0F0F_F0F0,
                                            64'h3C3C_C3C3_9669_6996};

  typedef struct packed {
    logic [1:0]       idx;
    logic [WIDTH-1:0] data;
  } beat_t;

  logic             clk;
  logic             rst_n;
  logic [3:0]       req;
  logic [WIDTH-1:0] data0, data1, data2, data3;
  logic             bus_ready;
  logic [3:0]       gnt;
  logic [1:0]       sel;
  logic             bus_valid;
  logic [WIDTH-1:0] bus_data;
  logic             busy;

  int    vectors;
  int    miscompares;
  beat_t sb_q[$];

  mux4_rr_arbiter #(.WIDTH(WIDTH), .MAX_BEATS(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .data0     (data0),
    .data1     (data1),
    .data2     (data2),
    .data3     (data3),
    .bus_ready (bus_ready),
    .gnt       (gnt),
    .sel       (sel),
    .bus_valid (bus_valid),
    .bus_data  (bus_data),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Beat monitor: a beat is accepted at the next rising edge.
  always @(negedge clk) begin
    if (rst_n && bus_valid && bus_ready) begin
      vectors++;
      if (sb_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_beat: got sel=%0d data=%h, required no beat", sel, bus_data);
      end else begin
        beat_t e;
        e = sb_q.pop_front();
        if (sel !== e.idx || bus_data !== e.data) begin
          miscompares++;
          $display("FAIL beat: got sel=%0d data=%h, required sel=%0d data=%h",
                   sel, bus_data, e.idx, e.data);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_beats(input logic [1:0] idx, input int n);
    beat_t e;
    for (int i = 0; i < n; i++) begin
      e.idx  = idx;
      e.data = DPAT[idx];
      sb_q.push_back(e);
    end
  endtask

  task automatic do_reset();
    req       = 4'b0000;
    bus_ready = 1'b0;
    rst_n     = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    req       = 4'b1111;
    bus_ready = 1'b0;
    #3;
    repeat (2) begin
      tick();
      vectors++;
      if (gnt !== 4'b0000 || busy !== 1'b0 || bus_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_hold: got gnt=%b busy=%b valid=%b, required 0000/0/0", gnt, busy, bus_valid);
      end
      vectors++;
      if (sel !== 2'd0 || bus_data !== DPAT[0]) begin
        miscompares++;
        $display("FAIL reset_mux: got sel=%0d data=%h, required 0/%h", sel, bus_data, DPAT[0]);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    vectors++;
    if (gnt !== 4'b0001 || sel !== 2'd0 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_first_gnt: got gnt=%b sel=%0d busy=%b, required 0001/0/1", gnt, sel, busy);
    end
    req = 4'b0000;
    tick();
    vectors++;
    if (busy !== 1'b0 || gnt !== 4'b0000) begin
      miscompares++;
      $display("FAIL reset_drop_release: got gnt=%b busy=%b, required 0000/0", gnt, busy);
    end
  endtask

  task automatic test_single();
    logic [3:0] exp_gnt [7] = '{4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0000, 4'b0100, 4'b0000};
    do_reset();
    push_beats(2'd2, 4);
    req       = 4'b0100;
    bus_ready = 1'b1;
    for (int e = 0; e < 7; e++) begin
      tick();
      vectors++;
      if (gnt !== exp_gnt[e]) begin
        miscompares++;
        $display("FAIL single_gnt[%0d]: got %b, required %b", e, gnt, exp_gnt[e]);
      end
      // Drop the request right after the re-grant so it releases without a beat.
      if (e == 5) req = 4'b0000;
    end
    vectors++;
    if (sb_q.size() != 0) begin
      miscompares++;
      $display("FAIL single_beats: got %0d missing beats, required 0", sb_q.size());
    end
  endtask

  task automatic test_round_robin();
    logic [1:0] idx;
    logic [3:0] exp;
    do_reset();
    for (int k = 0; k < 5; k++) push_beats(2'(k % 4), 4);
    req       = 4'b1111;
    bus_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      idx = 2'(k % 4);
      for (int e = 1; e <= 5; e++) begin
        tick();
        exp = (e == 5) ? 4'b0000 : (4'b0001 << idx);
        vectors++;
        if (gnt !== exp || (e < 5 && sel !== idx)) begin
          miscompares++;
          $display("FAIL rr_gnt[k%0d e%0d]: got gnt=%b sel=%0d, required gnt=%b sel=%0d",
                   k, e, gnt, sel, exp, idx);
        end
      end
    end
    req = 4'b0000;
    tick();
    vectors++;
    if (busy !== 1'b0 || sb_q.size() != 0) begin
      miscompares++;
      $display("FAIL rr_end: got busy=%b pending=%0d, required 0/0", busy, sb_q.size());
    end
  endtask

  task automatic test_early_drop();
    do_reset();
    push_beats(2'd1, 2);
    req       = 4'b0010;
    bus_ready = 1'b1;
    repeat (3) tick();
    req = 4'b1101;
    tick();
    vectors++;
    if (gnt !== 4'b0000 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL drop_release: got gnt=%b busy=%b, required 0000/0", gnt, busy);
    end
    tick();
    vectors++;
    if (gnt !== 4'b0100 || sel !== 2'd2) begin
      miscompares++;
      $display("FAIL drop_next_gnt: got gnt=%b sel=%0d, required 0100/2", gnt, sel);
    end
    req = 4'b0000;
    tick();
    vectors++;
    if (busy !== 1'b0 || sb_q.size() != 0) begin
      miscompares++;
      $display("FAIL drop_end: got busy=%b pending=%0d, required 0/0", busy, sb_q.size());
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    req       = 4'b1000;
    bus_ready = 1'b0;
    tick();
    for (int c = 0; c < 10; c++) begin
      tick();
      vectors++;
      if (gnt !== 4'b1000 || bus_valid !== 1'b1 || dut.beat_cnt !== '0 || bus_data !== DPAT[3]) begin
        miscompares++;
        $display("FAIL bp_hold[%0d]: got gnt=%b valid=%b cnt=%0d, required 1000/1/0",
                 c, gnt, bus_valid, dut.beat_cnt);
      end
    end
    push_beats(2'd3, 4);
    bus_ready = 1'b1;
    for (int e = 1; e <= 4; e++) begin
      tick();
      vectors++;
      if (gnt !== ((e == 4) ? 4'b0000 : 4'b1000)) begin
        miscompares++;
        $display("FAIL bp_burst[%0d]: got gnt=%b, required %b", e, gnt, (e == 4) ? 4'b0000 : 4'b1000);
      end
    end
    req = 4'b0000;
    tick();
    vectors++;
    if (busy !== 1'b0 || sb_q.size() != 0) begin
      miscompares++;
      $display("FAIL bp_end: got busy=%b pending=%0d, required 0/0", busy, sb_q.size());
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    bus_ready = 1'b1;
    req       = 4'b0010;
    tick();
    req = 4'b0000;
    tick();
    req = 4'b0100;
    push_beats(2'd2, 2);
    repeat (3) tick();
    vectors++;
    if (gnt !== 4'b0100) begin
      miscompares++;
      $display("FAIL ar_pre: got gnt=%b, required 0100", gnt);
    end
    req = 4'b1111;
    #1 rst_n = 1'b0;
    #1;
    vectors++;
    if (gnt !== 4'b0000 || busy !== 1'b0 || bus_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL ar_immediate: got gnt=%b busy=%b valid=%b, required 0000/0/0", gnt, busy, bus_valid);
    end
    #1 rst_n = 1'b1;
    tick();
    vectors++;
    if (gnt !== 4'b0001 || sel !== 2'd0) begin
      miscompares++;
      $display("FAIL ar_ptr_reset: got gnt=%b sel=%0d, required 0001/0", gnt, sel);
    end
    req = 4'b0000;
    tick();
    vectors++;
    if (busy !== 1'b0 || sb_q.size() != 0) begin
      miscompares++;
      $display("FAIL ar_end: got busy=%b pending=%0d, required 0/0", busy, sb_q.size());
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    data0       = DPAT[0];
    data1       = DPAT[1];
    data2       = DPAT[2];
    data3       = DPAT[3];
    test_reset();
    test_single();
    test_round_robin();
    test_early_drop();
    test_backpressure();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
